multi_stage_comb_lock: RTL and testbench

Parametrised successor of the three-stage combination lock. Accepts a combination of `STAGES` entries of `DIGITS` one-hot decimal digits each, delivered through a valid-qualified entry port that does not have to be back-to-back. It adds a failed-attempt counter with timed lockout, an inter-entry timeout, a timed open window, and re-programming of the stored combination while open. It sits between the keypad front end and the latch actuator driver.

---
 rtl/multi_stage_comb_lock.sv | 241 ++++++++++++++++++++++++
 tb/tb_multi_stage_comb_lock.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_stage_comb_lock.sv
// multi_stage_comb_lock
//   Combination lock that sits between the keypad front end and the latch
//   actuator driver. It accepts a combination of STAGES entries of DIGITS
//   one-hot decimal digits each, through a valid-qualified entry port. It
//   also provides:
//     - a failed-attempt counter with a timed lockout,
//     - an inter-entry timeout,
//     - a timed open window,
//     - re-programming of the stored combination while the lock is open.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   entry_valid  entry strobe, one entry per high cycle
//   entry        DIGITS x 10-bit one-hot digits, digit d in [d*10+9:d*10]
//   override     forces open from IDLE/LOCKOUT (only when OVERRIDE_EN=1)
//   set_req      request re-programming, honoured only while open
//   open         latch release (registered)
//   locked_out   high throughout lockout (registered)
//   prog_active  high throughout programming (registered)
//   fail_cnt     consecutive failed attempts, saturates at MAX_FAILS
//   stage        index of the next expected entry
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | collecting entries, comparing against stored combination
// OPEN    | latch released for OPEN_CYCLES, set_req moves to PROG
// PROG    | capturing a new combination into the shadow buffer
// LOCKOUT | too many failures, all input ignored for LOCKOUT_CYCLES
module multi_stage_comb_lock #(
  parameter int DIGITS         = 4,
  parameter int STAGES         = 3,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 8,
  parameter int ENTRY_TIMEOUT  = 32,
  parameter bit OVERRIDE_EN    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           entry_valid,
  input  logic [DIGITS*10-1:0]           entry,
  input  logic                           override,
  input  logic                           set_req,
  output logic                           open,
  output logic                           locked_out,
  output logic                           prog_active,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic [$clog2(STAGES)-1:0]      stage
);

  localparam int EW = DIGITS * 10;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int SW = $clog2(STAGES);
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TW = $clog2(ENTRY_TIMEOUT + 1);

  localparam logic [EW-1:0] ZERO_ENTRY = {DIGITS{10'd1}};
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS - 1);
  localparam logic [OW-1:0] OPEN_LOAD  = OW'(OPEN_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(ENTRY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_PROG    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t                   state_q, state_nxt;
  logic [SW-1:0]            stage_q, stage_nxt;
  logic [SW-1:0]            pidx_q, pidx_nxt;
  logic [FW-1:0]            fail_q, fail_nxt;
  logic [OW-1:0]            win_q, win_nxt;
  logic [LW-1:0]            lock_q, lock_nxt;
  logic [TW-1:0]            tmo_q, tmo_nxt;
  logic [STAGES-1:0][EW-1:0] stored_q, stored_nxt;
  logic [STAGES-1:0][EW-1:0] shadow_q, shadow_nxt;

  logic ovr;
  logic entry_ok;
  logic entry_match;

  function automatic logic well_formed(input logic [EW-1:0] e);
    logic       ok;
    logic [9:0] f;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      f = e[d*10 +: 10];
      if (f == 10'd0 || (f & (f - 10'd1)) != 10'd0) ok = 1'b0;
    end
    return ok;
  endfunction

  assign ovr         = OVERRIDE_EN && override;
  assign entry_ok    = well_formed(entry);
  // A malformed entry never matches, even if the stored value is malformed.
  assign entry_match = entry_ok && (entry == stored_q[stage_q]);

  always_comb begin
    state_nxt  = state_q;
    stage_nxt  = stage_q;
    pidx_nxt   = pidx_q;
    fail_nxt   = fail_q;
    win_nxt    = win_q;
    lock_nxt   = lock_q;
    tmo_nxt    = tmo_q;
    stored_nxt = stored_q;
    shadow_nxt = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (ovr) begin
          state_nxt = S_OPEN;
          stage_nxt = '0;
          fail_nxt  = '0;
          win_nxt   = OPEN_LOAD;
          tmo_nxt   = TMO_LOAD;
        end else if (entry_valid) begin
          tmo_nxt = TMO_LOAD;
          if (entry_match) begin
            if (stage_q == LAST_STAGE) begin
              state_nxt = S_OPEN;
              stage_nxt = '0;
              fail_nxt  = '0;
              win_nxt   = OPEN_LOAD;
            end else begin
              stage_nxt = stage_q + SW'(1);
            end
          end else begin
            // The failing entry is consumed, not re-tried as stage 0.
            stage_nxt = '0;
            if (fail_q == FAIL_LIMIT) begin
              fail_nxt  = FW'(MAX_FAILS);
              state_nxt = S_LOCKOUT;
              lock_nxt  = LOCK_LOAD;
            end else begin
              fail_nxt = fail_q + FW'(1);
            end
          end
        end else if (stage_q != '0) begin
          if (tmo_q == '0) begin
            stage_nxt = '0;
            tmo_nxt   = TMO_LOAD;
          end else begin
            tmo_nxt = tmo_q - TW'(1);
          end
        end
      end

      S_OPEN: begin
        if (set_req) begin
          state_nxt = S_PROG;
          pidx_nxt  = '0;
        end else if (win_q == '0) begin
          state_nxt = S_IDLE;
          tmo_nxt   = TMO_LOAD;
        end else begin
          win_nxt = win_q - OW'(1);
        end
      end

      S_PROG: begin
        if (entry_valid) begin
          if (!entry_ok) begin
            state_nxt = S_IDLE;
            pidx_nxt  = '0;
            tmo_nxt   = TMO_LOAD;
          end else begin
            shadow_nxt[pidx_q] = entry;
            if (pidx_q == LAST_STAGE) begin
              stored_nxt = shadow_nxt;
              state_nxt  = S_IDLE;
              pidx_nxt   = '0;
              tmo_nxt    = TMO_LOAD;
            end else begin
              pidx_nxt = pidx_q + SW'(1);
            end
          end
        end
      end

      S_LOCKOUT: begin
        if (ovr) begin
          state_nxt = S_OPEN;
          stage_nxt = '0;
          fail_nxt  = '0;
          win_nxt   = OPEN_LOAD;
        end else if (lock_q == '0) begin
          state_nxt = S_IDLE;
          fail_nxt  = '0;
          tmo_nxt   = TMO_LOAD;
        end else begin
          lock_nxt = lock_q - LW'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        stage_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      pidx_q      <= '0;
      fail_q      <= '0;
      win_q       <= '0;
      lock_q      <= '0;
      tmo_q       <= TMO_LOAD;
      stored_q    <= {STAGES{ZERO_ENTRY}};
      shadow_q    <= {STAGES{ZERO_ENTRY}};
      open        <= 1'b0;
      locked_out  <= 1'b0;
      prog_active <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      stage_q     <= stage_nxt;
      pidx_q      <= pidx_nxt;
      fail_q      <= fail_nxt;
      win_q       <= win_nxt;
      lock_q      <= lock_nxt;
      tmo_q       <= tmo_nxt;
      stored_q    <= stored_nxt;
      shadow_q    <= shadow_nxt;
      open        <= (state_nxt == S_OPEN);
      locked_out  <= (state_nxt == S_LOCKOUT);
      prog_active <= (state_nxt == S_PROG);
    end
  end

  assign fail_cnt = fail_q;
  assign stage    = stage_q;

endmodule

// File: tb/tb_multi_stage_comb_lock.sv
module tb_multi_stage_comb_lock;
  localparam int DIGITS = 4;
  localparam int EW     = DIGITS * 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          entry_valid = 1'b0;
  logic [EW-1:0] entry = '0;
  logic          override = 1'b0;
  logic          set_req = 1'b0;

  logic       open, locked_out, prog_active;
  logic [1:0] fail_cnt, stage;
  logic       open_n, locked_out_n, prog_active_n;
  logic [1:0] fail_cnt_n, stage_n;

  always #5 clk = ~clk;

  multi_stage_comb_lock #(.OVERRIDE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .entry_valid(entry_valid), .entry(entry),
    .override(override), .set_req(set_req), .open(open),
    .locked_out(locked_out), .prog_active(prog_active),
    .fail_cnt(fail_cnt), .stage(stage)
  );

  multi_stage_comb_lock #(.OVERRIDE_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .entry_valid(entry_valid), .entry(entry),
    .override(override), .set_req(set_req), .open(open_n),
    .locked_out(locked_out_n), .prog_active(prog_active_n),
    .fail_cnt(fail_cnt_n), .stage(stage_n)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         name;
    logic          ev;
    logic [EW-1:0] ent;
    logic          sreq;
    int            o, l, p, f, s;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // digit 0 is the least significant decimal digit of v
  function automatic logic [EW-1:0] enc(input int v);
    logic [EW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*10 + (x % 10)] = 1'b1;
      x = x / 10;
    end
    return r;
  endfunction

  task automatic add(input string nm, input logic ev, input logic [EW-1:0] ent,
                     input logic sreq, input int o, input int l, input int p,
                     input int f, input int s);
    vec_t v;
    v.name = nm; v.ev = ev; v.ent = ent; v.sreq = sreq;
    v.o = o; v.l = l; v.p = p; v.f = f; v.s = s;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int o, input int l, input int p,
                         input int f, input int s);
    chk($sformatf("%s.open", nm), int'(open), o);
    chk($sformatf("%s.locked_out", nm), int'(locked_out), l);
    chk($sformatf("%s.prog_active", nm), int'(prog_active), p);
    chk($sformatf("%s.fail_cnt", nm), int'(fail_cnt), f);
    chk($sformatf("%s.stage", nm), int'(stage), s);
  endtask

  task automatic drive(input logic ev, input logic [EW-1:0] ent);
    entry_valid = ev;
    entry = ent;
    step();
  endtask

  initial begin
    logic [EW-1:0] mal;
    mal = enc(0);
    mal[9:0] = 10'b0000000011;

    // default combination opens, window is 8 cycles
    add("unlk1", 1, enc(0), 0, 0, 0, 0, 0, 1);
    add("unlk2", 1, enc(0), 0, 0, 0, 0, 0, 2);
    add("unlk3", 1, enc(0), 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add("openwin", 0, '0, 0, 1, 0, 0, 0, 0);
    add("close", 0, '0, 0, 0, 0, 0, 0, 0);
    // wrong entries and lockout
    add("wr_s0", 1, enc(0), 0, 0, 0, 0, 0, 1);
    add("wr_s1", 1, enc(1234), 0, 0, 0, 0, 1, 0);
    add("wr2", 1, enc(1234), 0, 0, 0, 0, 2, 0);
    add("wr3", 1, enc(1234), 0, 0, 1, 0, 3, 0);
    for (int k = 0; k < 3; k++) add("lk_right", 1, enc(0), 0, 0, 1, 0, 3, 0);
    for (int k = 0; k < 12; k++) add("lk_hold", 0, '0, 0, 0, 1, 0, 3, 0);
    add("lk_end", 0, '0, 0, 0, 0, 0, 0, 0);
    add("post1", 1, enc(0), 0, 0, 0, 0, 0, 1);
    add("post2", 1, enc(0), 0, 0, 0, 0, 0, 2);
    add("post3", 1, enc(0), 0, 1, 0, 0, 0, 0);
    // entries ignored while open, then reprogram to 2730,0000,2730
    add("open_ign", 1, enc(1234), 0, 1, 0, 0, 0, 0);
    add("setreq", 0, '0, 1, 0, 0, 1, 0, 0);
    add("pg0", 1, enc(2730), 0, 0, 0, 1, 0, 0);
    add("pg1", 1, enc(0), 0, 0, 0, 1, 0, 0);
    add("pg2", 1, enc(2730), 0, 0, 0, 0, 0, 0);
    add("old_fail", 1, enc(0), 0, 0, 0, 0, 1, 0);
    add("new1", 1, enc(2730), 0, 0, 0, 0, 1, 1);
    add("new2", 1, enc(0), 0, 0, 0, 0, 1, 2);
    add("new3", 1, enc(2730), 0, 1, 0, 0, 0, 0);
    // malformed entry aborts programming
    add("setreq2", 0, '0, 1, 0, 0, 1, 0, 0);
    add("ab0", 1, enc(0), 0, 0, 0, 1, 0, 0);
    add("ab1", 1, mal, 0, 0, 0, 0, 0, 0);
    add("keep1", 1, enc(2730), 0, 0, 0, 0, 0, 1);
    add("keep2", 1, enc(0), 0, 0, 0, 0, 0, 2);
    add("keep3", 1, enc(2730), 0, 1, 0, 0, 0, 0);

    // reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      entry_valid = tbl[i].ev;
      entry       = tbl[i].ent;
      set_req     = tbl[i].sreq;
      step();
      chk_all($sformatf("%s[%0d]", tbl[i].name, i),
              tbl[i].o, tbl[i].l, tbl[i].p, tbl[i].f, tbl[i].s);
    end
    entry_valid = 1'b0;
    set_req = 1'b0;

    // asynchronous reset while open drops outputs at once and restores defaults
    #2 rst = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(1, enc(0));
    drive(1, enc(0));
    drive(1, enc(0));
    chk_all("midrst_default", 1, 0, 0, 0, 0);

    // inter-entry timeout
    rst = 1'b1; #1; step(); rst = 1'b0;
    drive(1, enc(0));
    chk_all("tmo_start", 0, 0, 0, 0, 1);
    for (int k = 0; k < 31; k++) drive(0, '0);
    chk_all("tmo_31", 0, 0, 0, 0, 1);
    drive(0, '0);
    chk_all("tmo_32", 0, 0, 0, 0, 0);
    drive(1, enc(0));
    drive(1, enc(0));
    chk_all("tmo_no_open", 0, 0, 0, 0, 2);

    // override in lockout, both with and without OVERRIDE_EN
    rst = 1'b1; #1; step(); rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(1, enc(1234));
    chk_all("ovr_locked", 0, 1, 0, 3, 0);
    chk("ovr_n_locked", int'(locked_out_n), 1);
    override = 1'b1;
    drive(1, enc(0));
    override = 1'b0;
    chk_all("ovr_open", 1, 0, 0, 0, 0);
    chk("ovr_n.open", int'(open_n), 0);
    chk("ovr_n.locked_out", int'(locked_out_n), 1);
    chk("ovr_n.fail_cnt", int'(fail_cnt_n), 3);
    drive(0, '0);
    chk("ovr_open_hold", int'(open), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
